// File: rtl/register_file_if.sv
// Bus between the CPU decode stage and the 4x8 register file: read/write addresses, write data
// and the two combinational read-data returns.
interface register_file_if;
  logic [1:0] read_register1;
  logic [1:0] read_register2;
  logic [1:0] destination_register;
  logic       regdst;
  logic [7:0] regwritedata;
  logic       regwrite;
  logic [7:0] readdata1;
  logic [7:0] readdata2;

  modport master (
    output read_register1,
    output read_register2,
    output destination_register,
    output regdst,
    output regwritedata,
    output regwrite,
    input  readdata1,
    input  readdata2
  );

  modport slave (
    input  read_register1,
    input  read_register2,
    input  destination_register,
    input  regdst,
    input  regwritedata,
    input  regwrite,
    output readdata1,
    output readdata2
  );
endinterface

// File: rtl/register_file.sv
// 4-entry x 8-bit register file: two combinational read ports, one synchronous write port whose
// address is rd or rt depending on regdst.
module register_file (
  input  logic            CLK,
  input  logic            RESET,
  register_file_if.slave  rf
);
  localparam int unsigned DataW   = 8;
  localparam int unsigned NumRegs = 4;
  localparam int unsigned AddrW   = 2;

  logic [DataW-1:0] regs_q [NumRegs];
  logic [DataW-1:0] regs_d [NumRegs];
  logic [AddrW-1:0] waddr;

  always_comb begin
    waddr = rf.regdst ? rf.destination_register : rf.read_register2;
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (rf.regwrite) begin
      regs_d[waddr] = rf.regwritedata;
    end
  end

  // Reset wins over a same-cycle write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write bypass: reads see the stored value until the edge.
  always_comb begin
    rf.readdata1 = regs_q[rf.read_register1];
    rf.readdata2 = regs_q[rf.read_register2];
  end
endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file, checked against an array model of the
// four registers.
module tb_register_file;
  logic CLK;
  logic RESET;
  register_file_if rf ();

  register_file dut (
    .CLK   (CLK),
    .RESET (RESET),
    .rf    (rf.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] model [4];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given controls; inputs change while CLK is low.
  task automatic step(input logic rst, input logic we, input logic sel, input logic [1:0] rs,
                      input logic [1:0] rt, input logic [1:0] rd, input logic [7:0] data);
    logic [1:0] wa;
    @(negedge CLK);
    RESET                   = rst;
    rf.regwrite             = we;
    rf.regdst               = sel;
    rf.read_register1       = rs;
    rf.read_register2       = rt;
    rf.destination_register = rd;
    rf.regwritedata         = data;
    @(posedge CLK);
    wa = sel ? rd : rt;
    if (rst) begin
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
    end else if (we) begin
      model[wa] = data;
    end
    #1;
    RESET       = 1'b0;
    rf.regwrite = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [1:0] rs, input logic [1:0] rt);
    rf.read_register1 = rs;
    rf.read_register2 = rt;
    #1;
    check($sformatf("%s rd1[%0d]", tag, rs), rf.readdata1, model[rs]);
    check($sformatf("%s rd2[%0d]", tag, rt), rf.readdata2, model[rt]);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        check_read(tag, 2'(a), 2'(b));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET                   = 1'b0;
    rf.regwrite             = 1'b0;
    rf.regdst               = 1'b0;
    rf.read_register1       = 2'd0;
    rf.read_register2       = 2'd0;
    rf.destination_register = 2'd0;
    rf.regwritedata         = 8'h00;

    // Preload every register with non-zero data, then reset.
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 8'h11);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 8'h22);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 8'h33);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 8'h44);
    for (int i = 0; i < 4; i++) check_read("preload", 2'(i), 2'(3 - i));
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check_read("reset", 2'(i), 2'(i));
      check($sformatf("reset const rd1[%0d]", i), rf.readdata1, 8'h00);
    end

    // regdst=1 writes rd.
    step(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 2'd2, 8'hA5);
    check_read("wr_rd", 2'd2, 2'd0);
    check("wr_rd const", rf.readdata1, 8'hA5);
    check_read("wr_rd others", 2'd1, 2'd3);

    // regdst=0 writes rt; rd ignored.
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd1, 8'h3C);
    check("wr_rt const", rf.readdata2, 8'h3C);
    check_read("wr_rt", 2'd1, 2'd3);

    // regwrite=0 leaves everything alone.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'(i), 2'(i), 2'(i), 2'(3 - i), 8'hFF);
    sweep("nowrite");

    // Read during write: old value before the edge, new after.
    @(negedge CLK);
    rf.regwrite             = 1'b1;
    rf.regdst               = 1'b1;
    rf.destination_register = 2'd0;
    rf.regwritedata         = 8'h77;
    rf.read_register1       = 2'd0;
    rf.read_register2       = 2'd0;
    #1;
    check("rdw before", rf.readdata1, 8'h00);
    @(posedge CLK);
    model[0] = 8'h77;
    #1;
    rf.regwrite = 1'b0;
    check("rdw after", rf.readdata1, 8'h77);
    check("rdw after rd2", rf.readdata2, 8'h77);

    // Reset beats a same-cycle write.
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 8'h9E);
    step(1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 2'd1, 8'h55);
    check("rst_wins", rf.readdata1, 8'h00);
    sweep("rst_wins");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [1:0] rs;
      logic [1:0] rt;
      rs = 2'($urandom_range(0, 3));
      rt = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), rs, rt,
           2'($urandom_range(0, 3)), 8'($urandom));
      check_read("rand", rs, rt);
      if (n % 50 == 49) sweep("rand sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
